fifo_srl_almost_full_ctrl: RTL and testbench

Complete show-ahead FIFO built on SRL shift-register storage, with occupancy tracking, registered empty/full flags and a programmable almost-full threshold. It decouples producer and consumer kernels in the SpMV pipeline. Its registered `if_full_n` deasserts `GRACE_PERIOD` entries before the FIFO is physically full, so a producer behind pipeline registers can still land its in-flight writes.

---
 rtl/fifo_srl_almost_full_ctrl.sv | 113 +++++++++++
 tb/tb_fifo_srl_almost_full_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/fifo_srl_almost_full_ctrl.sv
// Show-ahead FIFO on SRL storage with registered empty/full flags and an almost-full margin.
// Optional: define FIFO_SRL_COUNT_EN to expose the registered occupancy as if_count.
module fifo_srl_almost_full_ctrl #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 4,
    parameter int DEPTH        = 16,
    parameter int GRACE_PERIOD = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] if_din,
    input  logic                  if_write,
    input  logic                  if_write_ce,
    output logic                  if_full_n,
    input  logic                  if_read,
    input  logic                  if_read_ce,
    output logic [DATA_WIDTH-1:0] if_dout,
    output logic                  if_empty_n,
`ifdef FIFO_SRL_COUNT_EN
    output logic [ADDR_WIDTH:0]   if_count,
`endif
    output logic                  err_overflow,
    output logic                  err_underflow
);

    localparam logic [ADDR_WIDTH:0]   DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   AF_C    = (ADDR_WIDTH+1)'(DEPTH - GRACE_PERIOD);
    localparam logic [ADDR_WIDTH:0]   ONE_C   = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] ONE_A   = (ADDR_WIDTH)'(1);

    (* shreg_extract = "yes" *) logic [DATA_WIDTH-1:0] storage [0:DEPTH-1];

    logic [ADDR_WIDTH:0]   cnt_reg;
    logic [ADDR_WIDTH:0]   cnt_next;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  wr_req;
    logic                  rd_req;
    logic                  wr_acc;
    logic                  rd_acc;
    logic                  empty_n_reg;
    logic                  full_n_reg;
    logic                  overflow_reg;
    logic                  underflow_reg;

    assign wr_req = if_write & if_write_ce;
    assign rd_req = if_read & if_read_ce;
    assign wr_acc = wr_req & (cnt_reg != DEPTH_C);
    assign rd_acc = rd_req & (cnt_reg != '0);

    // Newest entry sits at index 0, so the oldest lives at cnt-1; a simultaneous
    // read+write shifts and keeps cnt, leaving addr on the next-oldest entry.
    assign addr    = cnt_reg[ADDR_WIDTH-1:0] - ONE_A;
    assign if_dout = storage[addr];

    always_comb begin
        cnt_next = cnt_reg;
        if (wr_acc && !rd_acc) begin
            cnt_next = cnt_reg + ONE_C;
        end else if (rd_acc && !wr_acc) begin
            cnt_next = cnt_reg - ONE_C;
        end
    end

    // Storage is deliberately not reset so it maps onto SRL primitives.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            storage[0] <= if_din;
            for (int i = 1; i < DEPTH; i++) begin
                storage[i] <= storage[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_reg       <= '0;
            empty_n_reg   <= 1'b0;
            full_n_reg    <= 1'b1;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            cnt_reg     <= cnt_next;
            empty_n_reg <= (cnt_next != '0);
            full_n_reg  <= (cnt_next < AF_C);
            if (wr_req && (cnt_reg == DEPTH_C)) begin
                overflow_reg <= 1'b1;
            end
            if (rd_req && (cnt_reg == '0)) begin
                underflow_reg <= 1'b1;
            end
        end
    end

`ifdef FIFO_SRL_COUNT_EN
    logic [ADDR_WIDTH:0] count_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_reg <= '0;
        end else begin
            count_reg <= cnt_next;
        end
    end

    assign if_count = count_reg;
`endif

    assign if_empty_n    = empty_n_reg;
    assign if_full_n     = full_n_reg;
    assign err_overflow  = overflow_reg;
    assign err_underflow = underflow_reg;

endmodule

// File: tb/tb_fifo_srl_almost_full_ctrl.sv
// Directed bench for fifo_srl_almost_full_ctrl; checks if_count too when FIFO_SRL_COUNT_EN is defined.
module tb_fifo_srl_almost_full_ctrl;

    localparam int DW = 32;
    localparam int AW = 4;
    localparam int D  = 16;
    localparam int G  = 2;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [DW-1:0] if_din = '0;
    logic          if_write = 1'b0;
    logic          if_write_ce = 1'b0;
    logic          if_full_n;
    logic          if_read = 1'b0;
    logic          if_read_ce = 1'b0;
    logic [DW-1:0] if_dout;
    logic          if_empty_n;
    logic          err_overflow;
    logic          err_underflow;
`ifdef FIFO_SRL_COUNT_EN
    logic [AW:0]   if_count;
`endif

    int tests = 0;
    int fails = 0;

    fifo_srl_almost_full_ctrl #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(D), .GRACE_PERIOD(G)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .if_din(if_din),
        .if_write(if_write),
        .if_write_ce(if_write_ce),
        .if_full_n(if_full_n),
        .if_read(if_read),
        .if_read_ce(if_read_ce),
        .if_dout(if_dout),
        .if_empty_n(if_empty_n),
`ifdef FIFO_SRL_COUNT_EN
        .if_count(if_count),
`endif
        .err_overflow(err_overflow),
        .err_underflow(err_underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_cnt(input string tag, input int exp);
`ifdef FIFO_SRL_COUNT_EN
        chk(tag, 32'(if_count), 32'(exp));
`else
        if (exp < 0) $display("[TB] unreachable %s", tag);
`endif
    endtask

    // One clock transaction; outputs are sampled 1 time unit after the edge.
    task automatic cyc(input logic w, input logic wce, input logic [31:0] d,
                       input logic r, input logic rce);
        if_write    = w;
        if_write_ce = wce;
        if_din      = d;
        if_read     = r;
        if_read_ce  = rce;
        @(posedge clk);
        #1;
        if_write    = 1'b0;
        if_write_ce = 1'b0;
        if_read     = 1'b0;
        if_read_ce  = 1'b0;
        $display("[TB] wr=%0b/%0b rd=%0b/%0b din=%h -> empty_n=%0b full_n=%0b dout=%h ovf=%0b unf=%0b",
                 w, wce, r, rce, d, if_empty_n, if_full_n, if_dout, err_overflow, err_underflow);
    endtask

    initial begin
        // Reset
        repeat (3) @(posedge clk);
        #1;
        chk("rst_empty_n", 32'(if_empty_n), 32'd0);
        chk("rst_full_n", 32'(if_full_n), 32'd1);
        #4 reset_n = 1'b1;
        #2;
        chk("rel_empty_n", 32'(if_empty_n), 32'd0);
        chk("rel_full_n", 32'(if_full_n), 32'd1);
        chk("rel_ovf", 32'(err_overflow), 32'd0);
        chk("rel_unf", 32'(err_underflow), 32'd0);
        chk_cnt("rel_count", 0);

        // Single entry
        cyc(1, 1, 32'hA5A5_0001, 0, 0);
        chk("single_empty_n", 32'(if_empty_n), 32'd1);
        chk("single_dout", if_dout, 32'hA5A5_0001);
        chk_cnt("single_count", 1);
        cyc(0, 0, 0, 1, 1);
        chk("single_drained", 32'(if_empty_n), 32'd0);
        chk("single_unf", 32'(err_underflow), 32'd0);

        // Almost-full: full_n falls at 14 entries, 15 and 16 still land, 17th drops
        for (int i = 1; i <= 16; i++) begin
            cyc(1, 1, 32'(i), 0, 0);
            chk($sformatf("af_full_n_%0d", i), 32'(if_full_n), (i < D - G) ? 32'd1 : 32'd0);
        end
        chk("af_ovf_before", 32'(err_overflow), 32'd0);
        chk_cnt("af_count16", 16);
        cyc(1, 1, 32'd17, 0, 0);
        chk("af_ovf", 32'(err_overflow), 32'd1);
        chk_cnt("af_count_hold", 16);
        for (int k = 1; k <= 16; k++) begin
            chk($sformatf("drain_dout_%0d", k), if_dout, 32'(k));
            cyc(0, 0, 0, 1, 1);
            chk($sformatf("drain_full_n_%0d", k), 32'(if_full_n), (16 - k < D - G) ? 32'd1 : 32'd0);
        end
        chk("drain_empty", 32'(if_empty_n), 32'd0);

        // Simultaneous read/write at 5 entries
        for (int i = 0; i < 5; i++) cyc(1, 1, 32'(100 + i), 0, 0);
        for (int k = 0; k < 20; k++) begin
            chk($sformatf("rw_dout_%0d", k), if_dout, 32'(100 + k));
            cyc(1, 1, 32'(105 + k), 1, 1);
            chk($sformatf("rw_empty_n_%0d", k), 32'(if_empty_n), 32'd1);
        end
        chk_cnt("rw_count", 5);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("rw_tail_%0d", k), if_dout, 32'(120 + k));
            chk($sformatf("rw_tail_ne_%0d", k), 32'(if_empty_n), 32'd1);
            cyc(0, 0, 0, 1, 1);
        end
        chk("rw_final_empty", 32'(if_empty_n), 32'd0);
        chk("rw_unf", 32'(err_underflow), 32'd0);

        // Edge cases
        cyc(1, 0, 32'h0000_0BAD, 0, 0);
        chk("wce0_empty", 32'(if_empty_n), 32'd0);
        cyc(1, 1, 32'h0000_0055, 0, 0);
        cyc(0, 0, 0, 1, 0);
        chk("rce0_empty_n", 32'(if_empty_n), 32'd1);
        chk("rce0_dout", if_dout, 32'h0000_0055);
        cyc(0, 0, 0, 1, 1);
        chk("rd_last_empty", 32'(if_empty_n), 32'd0);
        chk("rd_last_unf", 32'(err_underflow), 32'd0);
        cyc(0, 0, 0, 1, 1);
        chk("unf_set", 32'(err_underflow), 32'd1);
        chk("unf_empty", 32'(if_empty_n), 32'd0);
        chk_cnt("unf_count", 0);
        cyc(1, 1, 32'h0000_0077, 1, 1);
        chk("rw_empty_ne", 32'(if_empty_n), 32'd1);
        chk("rw_empty_dout", if_dout, 32'h0000_0077);
        chk_cnt("rw_empty_count", 1);
        cyc(0, 0, 0, 1, 1);
        chk("rw_empty_one", 32'(if_empty_n), 32'd0);

        // Reset mid-stream at 9 entries
        for (int i = 0; i < 9; i++) cyc(1, 1, 32'(200 + i), 0, 0);
        chk("mid_dout", if_dout, 32'd200);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_empty_n", 32'(if_empty_n), 32'd0);
        chk("mid_rst_full_n", 32'(if_full_n), 32'd1);
        chk("mid_rst_ovf", 32'(err_overflow), 32'd0);
        chk("mid_rst_unf", 32'(err_underflow), 32'd0);
        chk_cnt("mid_rst_count", 0);
        #1 reset_n = 1'b1;
        cyc(1, 1, 32'hDEAD_0001, 0, 0);
        chk("post_empty_n", 32'(if_empty_n), 32'd1);
        chk("post_dout", if_dout, 32'hDEAD_0001);
        chk_cnt("post_count", 1);
        cyc(0, 0, 0, 1, 1);
        chk("post_drain", 32'(if_empty_n), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
